addsub_result_accumulator: RTL and testbench

- Downstream consumer of the combinational N-bit adder/subtractor's (N+1)-bit result.
- Interprets each result according to the op that produced it: add results are carry-extended unsigned, sub results are signed with the MSB as the negative flag.
- Sums BURST_LEN results into a signed accumulator.
- Hands the burst total downstream over a valid/ready handshake, then restarts.

---
 rtl/addsub_result_accumulator_pkg.sv | 18 +
 rtl/addsub_res_extend.sv | 22 ++
 rtl/addsub_result_accumulator.sv | 126 ++++++++++++
 tb/tb_addsub_result_accumulator.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_result_accumulator_pkg.sv
// Shared types for the add/sub result accumulator: FSM states, op encoding
// and the burst counter width helper.
package addsub_result_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    // A one-result burst still needs a 1-bit counter to keep widths legal.
    function automatic int cnt_width(input int burst_len);
        return (burst_len <= 1) ? 1 : $clog2(burst_len);
    endfunction

endpackage

// File: rtl/addsub_res_extend.sv
// Widens an (N+1)-bit adder/subtractor result to ACC_W bits: add results
// are carry-extended unsigned, sub results are sign-extended. Pure combinational.
module addsub_res_extend
    import addsub_result_accumulator_pkg::*;
#(
    parameter int N     = 8,
    parameter int ACC_W = 16
) (
    input  logic [N:0]       res,
    input  logic             add_sub,
    output logic [ACC_W-1:0] ext
);

    always_comb begin
        if (add_sub == OP_ADD) begin
            ext = {{(ACC_W-N-1){1'b0}}, res};
        end else begin
            ext = {{(ACC_W-N-1){res[N]}}, res};
        end
    end

endmodule

// File: rtl/addsub_result_accumulator.sv
// Sums BURST_LEN add/sub results into a signed accumulator and hands the total
// downstream over valid/ready; ADDSUB_ACC_SAT_EN selects saturation instead of wrap.
module addsub_result_accumulator
    import addsub_result_accumulator_pkg::*;
#(
    parameter int N         = 8,
    parameter int ACC_W     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic             Clk,
    input  logic             Rst_N,
    input  logic [N:0]       In_Res,
    input  logic             In_Add_Sub,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic             Clr,
    output logic [ACC_W-1:0] Sum_Out,
    output logic             Sum_Ovf,
    output logic             Sum_Valid,
    input  logic             Sum_Ready
);

    localparam int            CW   = cnt_width(BURST_LEN);
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] sum_raw;
    logic [ACC_W-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic             step_ovf;
    logic             accept;
    logic             last;

    addsub_res_extend #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_extend (
        .res     (In_Res),
        .add_sub (In_Add_Sub),
        .ext     (ext)
    );

    assign sum_raw  = acc + ext;
    // Signed overflow: both addends share a sign the result does not.
    assign step_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum_raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef ADDSUB_ACC_SAT_EN
    always_comb begin
        acc_nxt = sum_raw;
        if (step_ovf) begin
            acc_nxt = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign acc_nxt = sum_raw;
`endif

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        In_Ready  = 1'b0;
        Sum_Valid = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            ACCUM: begin
                In_Ready = 1'b1;
                accept   = In_Valid && !Clr;
                last     = accept && (cnt == LAST);
                if (last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                Sum_Valid = 1'b1;
                if (Sum_Ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
        if (Clr) begin
            state_nxt = ACCUM;
        end
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            Sum_Out <= '0;
            Sum_Ovf <= 1'b0;
        end else if (Clr) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            Sum_Out <= '0;
            Sum_Ovf <= 1'b0;
        end else if (accept) begin
            if (last) begin
                Sum_Out <= acc_nxt;
                Sum_Ovf <= ovf | step_ovf;
                acc     <= '0;
                cnt     <= '0;
                ovf     <= 1'b0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt + CW'(1);
                ovf <= ovf | step_ovf;
            end
        end
    end

endmodule

// File: tb/tb_addsub_result_accumulator.sv
// Randomized and directed bench for addsub_result_accumulator against an
// integer reference model; a second narrow-accumulator instance covers overflow.
module tb_addsub_result_accumulator;

    localparam int N       = 8;
    localparam int ACC_W   = 16;
    localparam int BL      = 4;
    localparam int ACC_W_S = 10;

    typedef bit [N:0] res_t;

    logic             Clk = 1'b0;
    logic             Rst_N;
    logic [N:0]       In_Res;
    logic             In_Add_Sub;
    logic             In_Valid;
    logic             In_Ready;
    logic             Clr;
    logic [ACC_W-1:0] Sum_Out;
    logic             Sum_Ovf;
    logic             Sum_Valid;
    logic             Sum_Ready;

    logic [N:0]         s_res;
    logic               s_add_sub;
    logic               s_valid;
    logic               s_in_ready;
    logic               s_clr;
    logic [ACC_W_S-1:0] s_sum_out;
    logic               s_sum_ovf;
    logic               s_sum_valid;
    logic               s_sum_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    addsub_result_accumulator #(.N(N), .ACC_W(ACC_W), .BURST_LEN(BL)) dut (
        .Clk(Clk), .Rst_N(Rst_N), .In_Res(In_Res), .In_Add_Sub(In_Add_Sub),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .Clr(Clr), .Sum_Out(Sum_Out),
        .Sum_Ovf(Sum_Ovf), .Sum_Valid(Sum_Valid), .Sum_Ready(Sum_Ready)
    );

    addsub_result_accumulator #(.N(N), .ACC_W(ACC_W_S), .BURST_LEN(BL)) dut_s (
        .Clk(Clk), .Rst_N(Rst_N), .In_Res(s_res), .In_Add_Sub(s_add_sub),
        .In_Valid(s_valid), .In_Ready(s_in_ready), .Clr(s_clr), .Sum_Out(s_sum_out),
        .Sum_Ovf(s_sum_ovf), .Sum_Valid(s_sum_valid), .Sum_Ready(s_sum_ready)
    );

    // Reference: value of one result given the op that produced it.
    function automatic int model_ext(input bit op, input res_t r);
        if (op) return int'(r);
        return r[N] ? int'(r) - (1 << (N + 1)) : int'(r);
    endfunction

    // Reference: signed running sum in a w-bit accumulator, wrap or clamp.
    function automatic void model_burst(input int e[$], input int w, output int sum, output bit ovf);
        int acc = 0;
        int hi  = (1 << (w - 1)) - 1;
        int lo  = -(1 << (w - 1));
        ovf = 1'b0;
        foreach (e[i]) begin
            int v;
            v = acc + e[i];
            if (v > hi || v < lo) begin
                ovf = 1'b1;
`ifdef ADDSUB_ACC_SAT_EN
                v = (v > hi) ? hi : lo;
`else
                v = (v > hi) ? v - (1 << w) : v + (1 << w);
`endif
            end
            acc = v;
        end
        sum = acc;
    endfunction

    task automatic push(input bit op, input res_t r);
        int guard = 0;
        @(negedge Clk);
        In_Valid = 1'b1; In_Add_Sub = op; In_Res = r;
        while (!In_Ready && guard < 50) begin
            @(negedge Clk);
            guard++;
        end
        n_checks++;
        if (!In_Ready) begin
            n_fail++;
            $display("FAIL push_timeout: In_Ready=%0b after %0d cycles, required 1", In_Ready, guard);
        end else begin
            @(posedge Clk);
        end
        #1 In_Valid = 1'b0;
    endtask

    task automatic drive_burst(input bit ops[BL], input res_t rs[BL], output int es, output bit eo);
        int e[$];
        for (int i = 0; i < BL; i++) begin
            push(ops[i], rs[i]);
            e.push_back(model_ext(ops[i], rs[i]));
        end
        model_burst(e, ACC_W, es, eo);
    endtask

    task automatic handshake(input int delay);
        repeat (delay) @(posedge Clk);
        @(negedge Clk) Sum_Ready = 1'b1;
        @(posedge Clk);
        #1 Sum_Ready = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++;
        if (In_Ready !== 1'b1 || Sum_Valid !== 1'b0 || Sum_Out !== '0 || Sum_Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%0b vld=%0b out=%0h ovf=%0b, required 1 0 0 0",
                     In_Ready, Sum_Valid, Sum_Out, Sum_Ovf);
        end
        n_checks++;
        if (s_in_ready !== 1'b1 || s_sum_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state_s: rdy=%0b vld=%0b, required 1 0", s_in_ready, s_sum_valid);
        end
    endtask

    task automatic test_add_burst;
        bit   ops[BL] = '{1, 1, 1, 1};
        res_t rs[BL]  = '{9'h1FE, 9'h001, 9'h0FF, 9'h000};
        int   e[$];
        int   es;
        bit   eo;
        for (int i = 0; i < BL; i++) begin
            push(ops[i], rs[i]);
            e.push_back(model_ext(ops[i], rs[i]));
            n_checks++;
            if (Sum_Valid !== (i == BL - 1)) begin
                n_fail++;
                $display("FAIL add_valid_timing: after accept %0d Sum_Valid=%0b, required %0b",
                         i, Sum_Valid, i == BL - 1);
            end
        end
        model_burst(e, ACC_W, es, eo);
        n_checks++;
        if (int'($signed(Sum_Out)) != es || Sum_Ovf !== eo) begin
            n_fail++;
            $display("FAIL add_burst: sum=%0d ovf=%0b, required %0d %0b", $signed(Sum_Out), Sum_Ovf, es, eo);
        end
        handshake(0);
    endtask

    task automatic test_mixed;
        bit   ops[BL] = '{0, 0, 1, 0};
        res_t rs[BL]  = '{9'h1FE, 9'h002, 9'h005, 9'h1FB};
        int   es;
        bit   eo;
        drive_burst(ops, rs, es, eo);
        n_checks++;
        if (Sum_Valid !== 1'b1 || int'($signed(Sum_Out)) != es || Sum_Ovf !== eo) begin
            n_fail++;
            $display("FAIL mixed_signs: vld=%0b sum=%0d ovf=%0b, required 1 %0d %0b",
                     Sum_Valid, $signed(Sum_Out), Sum_Ovf, es, eo);
        end
        handshake(1);
    endtask

    task automatic test_backpressure;
        bit               ops[BL];
        res_t             rs[BL];
        int               e[$];
        int               es;
        bit               eo;
        logic [ACC_W-1:0] held;
        for (int i = 0; i < BL; i++) begin
            ops[i] = 1'($urandom);
            rs[i]  = res_t'($urandom);
        end
        drive_burst(ops, rs, es, eo);
        held = Sum_Out;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            In_Valid = 1'b1; In_Add_Sub = 1'b1; In_Res = 9'h0AA;
            @(posedge Clk);
            #1;
            n_checks++;
            if (In_Ready !== 1'b0 || Sum_Valid !== 1'b1 || Sum_Out !== held) begin
                n_fail++;
                $display("FAIL backpressure_hold: cycle %0d rdy=%0b vld=%0b out=%0h, required 0 1 %0h",
                         c, In_Ready, Sum_Valid, Sum_Out, held);
            end
        end
        // 0x0AA stays offered through the handshake and must land exactly once, one cycle later.
        @(negedge Clk) Sum_Ready = 1'b1;
        @(posedge Clk);
        #1 Sum_Ready = 1'b0;
        n_checks++;
        if (Sum_Valid !== 1'b0 || In_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: vld=%0b rdy=%0b, required 0 1", Sum_Valid, In_Ready);
        end
        @(posedge Clk);
        #1 In_Valid = 1'b0;
        e.push_back(model_ext(1'b1, 9'h0AA));
        for (int i = 1; i < BL; i++) begin
            push(1'b0, 9'h1F0 + res_t'(i));
            e.push_back(model_ext(1'b0, 9'h1F0 + res_t'(i)));
        end
        model_burst(e, ACC_W, es, eo);
        n_checks++;
        if (Sum_Valid !== 1'b1 || int'($signed(Sum_Out)) != es) begin
            n_fail++;
            $display("FAIL backpressure_next_burst: vld=%0b sum=%0d, required 1 %0d",
                     Sum_Valid, $signed(Sum_Out), es);
        end
        handshake(0);
    endtask

    task automatic test_clr;
        int   e[$];
        int   es;
        bit   eo;
        bit   ops[BL] = '{1, 1, 1, 1};
        res_t rs[BL]  = '{9'h010, 9'h020, 9'h030, 9'h040};
        push(1'b1, 9'h100);
        push(1'b1, 9'h100);
        @(negedge Clk);
        Clr = 1'b1; In_Valid = 1'b1; In_Add_Sub = 1'b1; In_Res = 9'h077;
        @(posedge Clk);
        #1 Clr = 1'b0; In_Valid = 1'b0;
        for (int i = 0; i < BL; i++) begin
            push(1'b1, 9'h003 + res_t'(i));
            e.push_back(model_ext(1'b1, 9'h003 + res_t'(i)));
            if (i == BL - 2) begin
                n_checks++;
                if (Sum_Valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clr_early_valid: Sum_Valid=%0b after 3 accepts, required 0", Sum_Valid);
                end
            end
        end
        model_burst(e, ACC_W, es, eo);
        n_checks++;
        if (Sum_Valid !== 1'b1 || int'($signed(Sum_Out)) != es) begin
            n_fail++;
            $display("FAIL clr_burst: vld=%0b sum=%0d, required 1 %0d", Sum_Valid, $signed(Sum_Out), es);
        end
        // Clear while a total is waiting in DRAIN.
        @(negedge Clk) Clr = 1'b1;
        @(posedge Clk);
        #1 Clr = 1'b0;
        n_checks++;
        if (Sum_Valid !== 1'b0 || In_Ready !== 1'b1 || Sum_Out !== '0 || Sum_Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_in_drain: vld=%0b rdy=%0b out=%0h ovf=%0b, required 0 1 0 0",
                     Sum_Valid, In_Ready, Sum_Out, Sum_Ovf);
        end
        drive_burst(ops, rs, es, eo);
        n_checks++;
        if (int'($signed(Sum_Out)) != es) begin
            n_fail++;
            $display("FAIL clr_after_drain: sum=%0d, required %0d", $signed(Sum_Out), es);
        end
        handshake(0);
    endtask

    task automatic test_reset_in_drain;
        bit   ops[BL] = '{1, 0, 1, 0};
        res_t rs[BL]  = '{9'h0F0, 9'h1F0, 9'h011, 9'h002};
        int   es;
        bit   eo;
        drive_burst(ops, rs, es, eo);
        #2 Rst_N = 1'b0;
        #1;
        n_checks++;
        if (Sum_Valid !== 1'b0 || In_Ready !== 1'b1 || Sum_Out !== '0) begin
            n_fail++;
            $display("FAIL reset_in_drain: vld=%0b rdy=%0b out=%0h, required 0 1 0", Sum_Valid, In_Ready, Sum_Out);
        end
        @(negedge Clk) Rst_N = 1'b1;
        // Mid-burst reset: the partial sum must not leak into the next total.
        push(1'b1, 9'h055);
        @(negedge Clk) Rst_N = 1'b0;
        @(negedge Clk) Rst_N = 1'b1;
        drive_burst(ops, rs, es, eo);
        n_checks++;
        if (Sum_Valid !== 1'b1 || int'($signed(Sum_Out)) != es) begin
            n_fail++;
            $display("FAIL reset_clears_acc: vld=%0b sum=%0d, required 1 %0d", Sum_Valid, $signed(Sum_Out), es);
        end
        handshake(0);
    endtask

    task automatic test_overflow;
        bit   ops[2][BL] = '{'{1, 1, 1, 1}, '{0, 0, 0, 0}};
        res_t rs[2][BL]  = '{'{9'h1FE, 9'h1FE, 9'h1FE, 9'h1FE}, '{9'h100, 9'h100, 9'h100, 9'h100}};
        for (int b = 0; b < 2; b++) begin
            int e[$];
            int es;
            bit eo;
            for (int i = 0; i < BL; i++) begin
                @(negedge Clk);
                s_valid = 1'b1; s_add_sub = ops[b][i]; s_res = rs[b][i];
                @(posedge Clk);
                #1 s_valid = 1'b0;
                e.push_back(model_ext(ops[b][i], rs[b][i]));
            end
            model_burst(e, ACC_W_S, es, eo);
            n_checks++;
            if (s_sum_valid !== 1'b1 || int'($signed(s_sum_out)) != es || s_sum_ovf !== eo) begin
                n_fail++;
                $display("FAIL overflow_%0d: vld=%0b sum=%0d ovf=%0b, required 1 %0d %0b",
                         b, s_sum_valid, $signed(s_sum_out), s_sum_ovf, es, eo);
            end
            @(negedge Clk) s_sum_ready = 1'b1;
            @(posedge Clk);
            #1 s_sum_ready = 1'b0;
        end
    endtask

    task automatic test_random;
        for (int b = 0; b < 25; b++) begin
            bit   ops[BL];
            res_t rs[BL];
            int   es;
            bit   eo;
            for (int i = 0; i < BL; i++) begin
                ops[i] = 1'($urandom);
                rs[i]  = res_t'($urandom);
            end
            drive_burst(ops, rs, es, eo);
            n_checks++;
            if (Sum_Valid !== 1'b1 || int'($signed(Sum_Out)) != es || Sum_Ovf !== eo) begin
                n_fail++;
                $display("FAIL random_burst_%0d: vld=%0b sum=%0d ovf=%0b, required 1 %0d %0b",
                         b, Sum_Valid, $signed(Sum_Out), Sum_Ovf, es, eo);
            end
            handshake(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        Rst_N = 1'b0;
        In_Res = '0; In_Add_Sub = 1'b0; In_Valid = 1'b0; Clr = 1'b0; Sum_Ready = 1'b0;
        s_res = '0; s_add_sub = 1'b0; s_valid = 1'b0; s_clr = 1'b0; s_sum_ready = 1'b0;
        repeat (3) @(negedge Clk);
        Rst_N = 1'b1;
        @(posedge Clk);
        #1;
        test_reset;
        test_add_burst;
        test_mixed;
        test_backpressure;
        test_clr;
        test_reset_in_drain;
        test_overflow;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
